// File: rtl/icache_fill_controller.sv
// Direct-mapped instruction cache with a word-by-word line-fill engine.
// Cacheable hits are served combinationally in the request cycle.
// A miss fetches the whole line starting at word 0.
// kseg1 addresses (0xA000_0000-0xBFFF_FFFF) bypass the cache. Each one
// is read as a single uncached word, and that word is served only to the
// fetch that requested it.
module icache_fill_controller #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        read,
  output logic [31:0] rdata,
  output logic        busy,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 32 - OB - IB - 2;

  localparam logic [OB-1:0] CNT_ONE   = OB'(1);
  localparam logic [OB-1:0] CNT_LAST  = OB'(LINE_WORDS - 1);
  localparam logic [OB-1:0] CNT_ZERO  = OB'(0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_BYPASS = 2'd2
  } state_t;

  state_t state_r, state_s;

  // Storage arrays
  logic [31:0]    data_r [LINES][LINE_WORDS];
  logic [TB-1:0]  tag_r  [LINES];
  logic [LINES-1:0] valid_r;

  // Fill / bypass bookkeeping
  logic [IB-1:0]  fill_index_r;
  logic [TB-1:0]  fill_tag_r;
  logic [OB-1:0]  word_cnt_r;
  logic           flush_pend_r;
  logic           bypass_hit_r;
  logic [29:0]    bypass_addr_r;
  logic [31:0]    bypass_data_r;
  logic [31:0]    mem_addr_r;
  logic           mem_read_r;

  // Decoded request fields
  logic [OB-1:0]  offset_s;
  logic [IB-1:0]  index_s;
  logic [TB-1:0]  tag_s;
  logic           kseg1_s;
  logic           hit_s;
  logic           byp_serve_s;
  logic           ready_ok_s;
  logic           last_word_s;
  logic           start_fill_s;
  logic           start_byp_s;
  logic           unused_s;

  assign offset_s    = addr[OB+1:2];
  assign index_s     = addr[OB+IB+1:OB+2];
  assign tag_s       = addr[31:OB+IB+2];
  assign kseg1_s     = (addr[31:29] == 3'b101);
  assign hit_s       = read && !kseg1_s && valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign byp_serve_s = read && kseg1_s && bypass_hit_r && (bypass_addr_r == addr[31:2]);
  // mem_ready outside an outstanding request carries no data for us
  assign ready_ok_s  = mem_ready && mem_read_r;
  assign last_word_s = (word_cnt_r == CNT_LAST);
  assign unused_s    = &{1'b0, addr[1:0]};

  assign mem_addr = mem_addr_r;
  assign mem_read = mem_read_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus the combinational busy/rdata response
  always_comb begin
    state_s      = state_r;
    busy         = 1'b0;
    rdata        = 32'h0000_0000;
    start_fill_s = 1'b0;
    start_byp_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (read) begin
          if (hit_s) begin
            rdata = data_r[index_s][offset_s];
          end else if (byp_serve_s) begin
            rdata = bypass_data_r;
          end else begin
            busy = 1'b1;
            if (flush) begin
              // flush wins; the request is re-evaluated as a miss next cycle
              state_s = ST_IDLE;
            end else if (kseg1_s) begin
              if (!bypass_hit_r) begin
                state_s     = ST_BYPASS;
                start_byp_s = 1'b1;
              end else begin
                // stale uncached word is dropped this cycle, fetch starts next
                state_s = ST_IDLE;
              end
            end else begin
              state_s      = ST_FILL;
              start_fill_s = 1'b1;
            end
          end
        end else begin
          rdata = 32'h0000_0000;
        end
      end
      ST_FILL: begin
        busy = 1'b1;
        if (ready_ok_s && last_word_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_BYPASS: begin
        busy = 1'b1;
        if (ready_ok_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BYPASS;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // External request address/strobe and fill bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_r   <= 32'h0000_0000;
      mem_read_r   <= 1'b0;
      fill_index_r <= '0;
      fill_tag_r   <= '0;
      word_cnt_r   <= CNT_ZERO;
      flush_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_fill_s) begin
            fill_index_r <= index_s;
            fill_tag_r   <= tag_s;
            word_cnt_r   <= CNT_ZERO;
            mem_addr_r   <= {tag_s, index_s, CNT_ZERO, 2'b00};
            mem_read_r   <= 1'b1;
            flush_pend_r <= 1'b0;
          end else if (start_byp_s) begin
            mem_addr_r   <= {addr[31:2], 2'b00};
            mem_read_r   <= 1'b1;
            flush_pend_r <= 1'b0;
          end
        end
        ST_FILL: begin
          if (flush) begin
            flush_pend_r <= 1'b1;
          end
          if (ready_ok_s) begin
            word_cnt_r <= word_cnt_r + CNT_ONE;
            mem_addr_r <= mem_addr_r + 32'd4;
            if (last_word_s) begin
              mem_read_r <= 1'b0;
            end
          end
        end
        ST_BYPASS: begin
          if (flush) begin
            flush_pend_r <= 1'b1;
          end
          if (ready_ok_s) begin
            mem_read_r <= 1'b0;
          end
        end
        default: begin
          mem_read_r <= 1'b0;
        end
      endcase
    end
  end

  // Uncached word holding register; valid only for the fetch that caused it
  always_ff @(posedge clk) begin
    if (reset) begin
      bypass_hit_r  <= 1'b0;
      bypass_addr_r <= 30'h0;
      bypass_data_r <= 32'h0000_0000;
    end else if ((state_r == ST_BYPASS) && ready_ok_s) begin
      bypass_data_r <= mem_rdata;
      bypass_addr_r <= mem_addr_r[31:2];
      bypass_hit_r  <= !(flush_pend_r || flush);
    end else if (flush) begin
      bypass_hit_r <= 1'b0;
    end else if (read && bypass_hit_r && (bypass_addr_r != addr[31:2])) begin
      bypass_hit_r <= 1'b0;
    end
  end

  // Line valid bits: set on clean fill completion, cleared by flush or new fill
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= '0;
    end else if ((state_r == ST_FILL) && ready_ok_s && last_word_s) begin
      if (flush_pend_r || flush) begin
        valid_r <= '0;
      end else begin
        valid_r[fill_index_r] <= 1'b1;
      end
    end else if (flush && (state_r == ST_IDLE)) begin
      valid_r <= '0;
    end else if (start_fill_s) begin
      valid_r[index_s] <= 1'b0;
    end
  end

  // Data and tag arrays, written as fill words return
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_FILL) && ready_ok_s) begin
      data_r[fill_index_r][word_cnt_r] <= mem_rdata;
      if (last_word_s) begin
        tag_r[fill_index_r] <= fill_tag_r;
      end
    end
  end

endmodule

// File: tb/tb_icache_fill_controller.sv
// Directed bench for icache_fill_controller: table of fetch requests with
// hand-computed busy-cycle counts, data and external traffic, plus
// hand-written flush and reset sequences. External memory answers each
// word two cycles after the request is seen.
module tb_icache_fill_controller;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        read;
  logic [31:0] rdata;
  logic        busy;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int errors = 0;
  int checks = 0;
  int viol   = 0;
  int wait_cnt = 0;
  logic [31:0] req_log[$];

  logic        prev_busy;
  logic        prev_read;
  logic [31:0] prev_addr;

  icache_fill_controller #(.LINE_WORDS(4), .LINES(16)) dut (
    .clk(clk), .reset(reset), .addr(addr), .read(read), .rdata(rdata),
    .busy(busy), .flush(flush), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: 0x100 line holds 0xA0..0xA3, kseg1 words encode their address
  function automatic logic [31:0] mem_value(input logic [31:0] a);
    if (a[31:29] == 3'b101) return {16'h3C08, a[31:16]} + {16'h0000, a[15:0]};
    else if (a[31:4] == 28'h000_0010) return 32'h0000_00A0 | {28'h0, 2'b00, a[3:2]};
    else return 32'hD000_0000 | a;
  endfunction

  // Memory responder: one-cycle mem_ready pulse two cycles after a request
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (reset) begin
      wait_cnt = 0;
    end else if (mem_read) begin
      if (wait_cnt == 1) begin
        mem_ready = 1'b1;
        mem_rdata = mem_value(mem_addr);
        req_log.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Requester protocol monitor: addr must not move while a request is busy
  always @(negedge clk) begin
    if (!reset && prev_busy && prev_read && read && (addr != prev_addr)) viol = viol + 1;
    prev_busy = busy;
    prev_read = read;
    prev_addr = addr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a fetch and wait until it is served; optionally pulse flush
  // at busy cycle flush_at.
  task automatic do_read(input logic [31:0] a, input int flush_at,
                         output int nbusy, output logic [31:0] data);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    @(posedge clk);
    #1;
    addr = a;
    read = 1'b1;
    req_log.delete();
    while (!done) begin
      @(negedge clk);
      if (flush) flush = 1'b0;
      if (!busy) begin
        done = 1'b1;
      end else begin
        if (n == flush_at) flush = 1'b1;
        n = n + 1;
        if (n > 200) done = 1'b1;
      end
    end
    nbusy = n;
    data  = rdata;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          exp_busy;
    logic [31:0] exp_rdata;
    int          exp_reqs;
    logic [31:0] exp_addr0;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    int nb;
    int tmo;
    logic [31:0] d;

    vecs[0]  = '{32'h0000_0104, 9, 32'h0000_00A1, 4, 32'h0000_0100};
    vecs[1]  = '{32'h0000_0100, 0, 32'h0000_00A0, 0, 32'h0000_0000};
    vecs[2]  = '{32'h0000_0108, 0, 32'h0000_00A2, 0, 32'h0000_0000};
    vecs[3]  = '{32'h0000_010C, 0, 32'h0000_00A3, 0, 32'h0000_0000};
    vecs[4]  = '{32'h0000_1100, 9, 32'hD000_1100, 4, 32'h0000_1100};
    vecs[5]  = '{32'h0000_0100, 9, 32'h0000_00A0, 4, 32'h0000_0100};
    vecs[6]  = '{32'h0000_1104, 9, 32'hD000_1104, 4, 32'h0000_1100};
    vecs[7]  = '{32'h0000_0210, 9, 32'hD000_0210, 4, 32'h0000_0210};
    vecs[8]  = '{32'hBFC0_0000, 3, 32'h3C08_BFC0, 1, 32'hBFC0_0000};
    vecs[9]  = '{32'hBFC0_0004, 4, 32'h3C08_BFC4, 1, 32'hBFC0_0004};
    vecs[10] = '{32'hBFC0_0004, 0, 32'h3C08_BFC4, 0, 32'h0000_0000};
    vecs[11] = '{32'h0000_0104, 9, 32'h0000_00A1, 4, 32'h0000_0100};
    vecs[12] = '{32'h0000_021C, 0, 32'hD000_021C, 0, 32'h0000_0000};
    vecs[13] = '{32'h0000_0108, 0, 32'h0000_00A2, 0, 32'h0000_0000};

    reset = 1'b1;
    read = 1'b0;
    flush = 1'b0;
    addr = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_mem_read", {31'h0, mem_read}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Table of fetches
    for (int i = 0; i < NV; i++) begin
      do_read(vecs[i].addr, -1, nb, d);
      check($sformatf("v%0d_busy_cycles", i), nb, vecs[i].exp_busy);
      check($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
      check($sformatf("v%0d_mem_reqs", i), req_log.size(), vecs[i].exp_reqs);
      if (vecs[i].exp_reqs > 0)
        check($sformatf("v%0d_mem_addr0", i), req_log[0], vecs[i].exp_addr0);
      if (i == 0) begin
        for (int k = 1; k < 4; k++)
          check($sformatf("v0_mem_addr%0d", k), req_log[k], 32'h0000_0100 + 32'(4 * k));
      end
    end

    // Flush during fill of 0x200: fill finishes, then the line refills
    do_read(32'h0000_0200, 3, nb, d);
    check("flushfill_busy_cycles", nb, 18);
    check("flushfill_rdata", d, 32'hD000_0200);
    check("flushfill_mem_reqs", req_log.size(), 8);
    check("flushfill_refill_addr", req_log[4], 32'h0000_0200);
    do_read(32'h0000_0204, -1, nb, d);
    check("after_refill_hit_busy", nb, 0);
    check("after_refill_hit_rdata", d, 32'hD000_0204);

    // Flush while idle clears every line
    @(posedge clk);
    #1 read = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    do_read(32'h0000_0204, -1, nb, d);
    check("idleflush_l0_busy", nb, 9);
    check("idleflush_l0_rdata", d, 32'hD000_0204);
    do_read(32'h0000_0210, -1, nb, d);
    check("idleflush_l1_busy", nb, 9);
    check("idleflush_l1_reqs", req_log.size(), 4);

    // Reset during word 2 of a fill
    @(posedge clk);
    #1 addr = 32'h0000_0100;
    read = 1'b1;
    req_log.delete();
    tmo = 0;
    while (req_log.size() < 2 && tmo < 50) begin
      @(negedge clk);
      tmo = tmo + 1;
    end
    check("midreset_reached_word2", req_log.size(), 2);
    @(posedge clk);
    #1 reset = 1'b1;
    read = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_mem_read", {31'h0, mem_read}, 32'h0);
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    do_read(32'h0000_0100, -1, nb, d);
    check("postreset_busy", nb, 9);
    check("postreset_rdata", d, 32'h0000_00A0);
    check("postreset_reqs", req_log.size(), 4);

    check("addr_stable_while_busy", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
